sha_const_fetch_ctrl: RTL and testbench

Sequences reads from the four 8K x 8 constant EEPROM byte slices. The slices hold SHA-256 H0..H7 at byte addresses 0..7 and K0..K63 at addresses 8..71.
Arbitrates two requesters onto the shared ROM bus:
- H port: hash-state initialiser.
- K port: round scheduler.
Assembles each 32-bit word, with slice 1 as MSB and slice 4 as LSB. Generates the active-low CE/OE/WE strobes with a programmable access wait.

---
 rtl/sha_const_pkg.sv | 22 ++
 rtl/sha_rom_timing.sv | 67 ++++++
 rtl/sha_const_fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sha_const_fetch_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_const_pkg.sv
// Shared types and constants for the SHA-256 constant ROM fetch controller.
// Optional K prefetch buffer is enabled by defining SHA_CONST_KPREFETCH_EN.
package sha_const_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        SEL_H = 1'b0,
        SEL_K = 1'b1
    } port_sel_t;

    localparam int H_BASE_DEF = 0;
    localparam int K_BASE_DEF = 8;
    localparam int H_WORDS    = 8;
    localparam int K_WORDS    = 64;

endpackage

// File: rtl/sha_rom_timing.sv
// ROM strobe sequencer: one SETUP cycle, then WAIT_CYCLES of OE low.
// Pulses o_capture on the last OE-low cycle so the parent can latch data.
module sha_rom_timing
    import sha_const_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_capture,
    output logic [ADDR_W-1:0] o_rom_a,
    output logic              o_ce_n,
    output logic              o_oe_n,
    output logic              o_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_t            r_ph;
    state_t            w_ph_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;

    // Phase, wait counter and latched address
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ph   <= S_IDLE;
            r_cnt  <= '0;
            r_addr <= '0;
        end else begin
            r_ph <= w_ph_nx;
            if (r_ph == S_IDLE && i_start)
                r_addr <= i_addr;
            if (r_ph == S_SETUP)
                r_cnt <= CNT_INIT;
            else if (r_ph == S_ACCESS && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    // Next phase and capture strobe
    always_comb begin
        w_ph_nx   = r_ph;
        o_capture = 1'b0;
        unique case (r_ph)
            S_IDLE:   if (i_start) w_ph_nx = S_SETUP;
            S_SETUP:  w_ph_nx = S_ACCESS;
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    o_capture = 1'b1;
                    w_ph_nx   = S_IDLE;
                end
            end
            default:  w_ph_nx = S_IDLE;
        endcase
    end

    assign o_rom_a = r_addr;
    assign o_ce_n  = (r_ph == S_IDLE);
    assign o_oe_n  = (r_ph != S_ACCESS);
    assign o_we_n  = 1'b1;

endmodule

// File: rtl/sha_const_fetch_ctrl.sv
// Arbitrates H/K word requests onto the shared constant ROM (K has priority).
// Define SHA_CONST_KPREFETCH_EN to add a one-entry speculative K+1 buffer.
module sha_const_fetch_ctrl
    import sha_const_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int H_BASE      = H_BASE_DEF,
    parameter int K_BASE      = K_BASE_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       H_REQ,
    input  logic [$clog2(H_WORDS)-1:0] H_IDX,
    output logic                       H_ACK,
    input  logic                       K_REQ,
    input  logic [$clog2(K_WORDS)-1:0] K_IDX,
    output logic                       K_ACK,
    output logic [31:0]                RDATA,
    output logic                       BUSY,
    output logic [ADDR_W-1:0]          ROM_A,
    output logic                       ROM_CE_N,
    output logic                       ROM_OE_N,
    output logic                       ROM_WE_N,
    input  logic [31:0]                ROM_D
);

    localparam int KI_W = $clog2(K_WORDS);

    state_t            r_state;
    state_t            w_state_nx;
    port_sel_t         r_sel;
    port_sel_t         w_sel_nx;
    logic              r_ack;
    logic [31:0]       r_rdata;
    logic              w_start;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_addr_h;
    logic [ADDR_W-1:0] w_addr_k;
    logic              w_capture;
    logic              w_gnt_req;
    logic              w_is_spec;

    assign w_addr_h  = ADDR_W'(H_BASE) + ADDR_W'(H_IDX);
    assign w_addr_k  = ADDR_W'(K_BASE) + ADDR_W'(K_IDX);
    assign w_gnt_req = (r_sel == SEL_K) ? K_REQ : H_REQ;

`ifdef SHA_CONST_KPREFETCH_EN
    localparam logic [KI_W-1:0] K_LAST = KI_W'(K_WORDS - 1);

    logic              r_pf_valid;
    logic [KI_W-1:0]   r_pf_idx;
    logic [31:0]       r_pf_word;
    logic [KI_W-1:0]   r_kidx;
    logic              r_pf_pend;
    logic              r_spec;
    logic              w_hit;
    logic              w_grant_k;
    logic              w_pf_go;
    logic [ADDR_W-1:0] w_addr_pf;

    assign w_hit     = r_pf_valid && (K_IDX == r_pf_idx);
    assign w_addr_pf = ADDR_W'(K_BASE) + ADDR_W'(r_kidx) + ADDR_W'(1);
    assign w_is_spec = r_spec;

    // Prefetch buffer: arm after a K handshake, fill on speculative capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
            r_pf_word  <= '0;
            r_kidx     <= '0;
            r_pf_pend  <= 1'b0;
            r_spec     <= 1'b0;
        end else begin
            if (w_grant_k)
                r_kidx <= K_IDX;
            if (r_state == S_DONE && w_state_nx == S_IDLE &&
                r_sel == SEL_K && r_kidx != K_LAST)
                r_pf_pend <= 1'b1;
            else if (r_state == S_IDLE)
                r_pf_pend <= 1'b0;
            if (w_pf_go) begin
                r_spec     <= 1'b1;
                r_pf_idx   <= r_kidx + 1'b1;
                r_pf_valid <= 1'b0;
            end else if (w_capture && r_spec) begin
                r_spec     <= 1'b0;
                r_pf_valid <= 1'b1;
                r_pf_word  <= ROM_D;
            end
        end
    end
`else
    assign w_is_spec = 1'b0;
`endif

    // Arbitration and handshake next-state
    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_start    = 1'b0;
        w_addr     = w_addr_k;
`ifdef SHA_CONST_KPREFETCH_EN
        w_grant_k  = 1'b0;
        w_pf_go    = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (K_REQ) begin
                    w_sel_nx = SEL_K;
`ifdef SHA_CONST_KPREFETCH_EN
                    w_grant_k = 1'b1;
                    if (w_hit) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_start    = 1'b1;
                        w_state_nx = S_SETUP;
                    end
`else
                    w_start    = 1'b1;
                    w_state_nx = S_SETUP;
`endif
                end else if (H_REQ) begin
                    w_sel_nx   = SEL_H;
                    w_addr     = w_addr_h;
                    w_start    = 1'b1;
                    w_state_nx = S_SETUP;
                end
`ifdef SHA_CONST_KPREFETCH_EN
                else if (r_pf_pend) begin
                    w_pf_go    = 1'b1;
                    w_addr     = w_addr_pf;
                    w_start    = 1'b1;
                    w_state_nx = S_SETUP;
                end
`endif
            end
            S_SETUP:  w_state_nx = S_ACCESS;
            S_ACCESS: begin
                if (w_capture)
                    w_state_nx = w_is_spec ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (r_ack && !w_gnt_req)
                    w_state_nx = S_IDLE;
            end
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // State, grant, acknowledge and read data registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_H;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            if (w_capture && !w_is_spec) begin
                r_rdata <= ROM_D;
                r_ack   <= 1'b1;
            end
`ifdef SHA_CONST_KPREFETCH_EN
            else if (r_state == S_DONE && !r_ack) begin
                r_rdata <= r_pf_word;
                r_ack   <= 1'b1;
            end
`endif
            else if (r_state == S_DONE && w_state_nx == S_IDLE) begin
                r_ack <= 1'b0;
            end
        end
    end

    sha_rom_timing #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timing (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_start   (w_start),
        .i_addr    (w_addr),
        .o_capture (w_capture),
        .o_rom_a   (ROM_A),
        .o_ce_n    (ROM_CE_N),
        .o_oe_n    (ROM_OE_N),
        .o_we_n    (ROM_WE_N)
    );

    assign H_ACK = r_ack && (r_sel == SEL_H);
    assign K_ACK = r_ack && (r_sel == SEL_K);
    assign RDATA = r_rdata;
    assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sha_const_fetch_ctrl.sv
// Bench for sha_const_fetch_ctrl with an EEPROM model holding SHA-256 H/K.
// Prefetch checks run when SHA_CONST_KPREFETCH_EN is defined.
module tb_sha_const_fetch_ctrl;

    localparam int WAIT = 2;
    localparam int FULL_LAT = 2 + WAIT;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        H_REQ = 1'b0;
    logic [2:0]  H_IDX = '0;
    logic        H_ACK;
    logic        K_REQ = 1'b0;
    logic [5:0]  K_IDX = '0;
    logic        K_ACK;
    logic [31:0] RDATA;
    logic        BUSY;
    logic [12:0] ROM_A;
    logic        ROM_CE_N;
    logic        ROM_OE_N;
    logic        ROM_WE_N;
    logic [31:0] ROM_D;

    int total = 0;
    int bad = 0;

    logic [31:0] rom [0:71];

    bit pf_valid = 0;
    int pf_idx = 0;

    int  ce_starts = 0;
    logic ce_prev = 1'b1;
    bit  we_low_seen = 0;

    always #5 CLK = ~CLK;

    sha_const_fetch_ctrl #(
        .ADDR_W      (13),
        .H_BASE      (0),
        .K_BASE      (8),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .H_REQ    (H_REQ),
        .H_IDX    (H_IDX),
        .H_ACK    (H_ACK),
        .K_REQ    (K_REQ),
        .K_IDX    (K_IDX),
        .K_ACK    (K_ACK),
        .RDATA    (RDATA),
        .BUSY     (BUSY),
        .ROM_A    (ROM_A),
        .ROM_CE_N (ROM_CE_N),
        .ROM_OE_N (ROM_OE_N),
        .ROM_WE_N (ROM_WE_N),
        .ROM_D    (ROM_D)
    );

    // EEPROM model: data only visible while both CE and OE are low
    always_comb begin
        if (!ROM_CE_N && !ROM_OE_N && ROM_A < 13'd72)
            ROM_D = rom[ROM_A[6:0]];
        else
            ROM_D = 32'hDEAD_BEEF;
    end

    // Count ROM cycle starts and watch WE
    always @(negedge CLK) begin
        if (ce_prev && !ROM_CE_N)
            ce_starts++;
        ce_prev = ROM_CE_N;
        if (ROM_WE_N !== 1'b1)
            we_low_seen = 1;
    end

    function automatic int exp_lat(input bit is_k, input int idx);
`ifdef SHA_CONST_KPREFETCH_EN
        if (is_k && pf_valid && pf_idx == idx)
            return 2;
`endif
        return FULL_LAT;
    endfunction

    function automatic int exp_addr(input bit is_k, input int idx);
        return is_k ? 8 + idx : idx;
    endfunction

    task automatic do_req(input bit is_k, input int idx,
                          output int n, output logic [31:0] d,
                          output logic [12:0] a);
        @(negedge CLK);
        if (is_k) begin
            K_IDX = 6'(idx);
            K_REQ = 1'b1;
        end else begin
            H_IDX = 3'(idx);
            H_REQ = 1'b1;
        end
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            #1;
            n++;
            if ((is_k ? K_ACK : H_ACK) === 1'b1)
                break;
        end
        d = RDATA;
        a = ROM_A;
    endtask

    task automatic do_release(input bit is_k, input int idx,
                              input bit other_pending);
        @(negedge CLK);
        if (is_k) K_REQ = 1'b0;
        else      H_REQ = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if ((is_k ? K_ACK : H_ACK) === 1'b0)
                break;
        end
`ifdef SHA_CONST_KPREFETCH_EN
        if (is_k && !other_pending && idx < 63) begin
            pf_valid = 1;
            pf_idx = idx + 1;
        end
`endif
        if (!other_pending)
            repeat (8) @(posedge CLK);
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({H_ACK, K_ACK, BUSY} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {H_ACK, K_ACK, BUSY});
        end
        total++;
        if (RDATA !== 32'h0 || ROM_A !== 13'h0) begin
            bad++;
            $display("FAIL reset_data got rdata=%h a=%0d want 0/0", RDATA, ROM_A);
        end
        total++;
        if ({ROM_CE_N, ROM_OE_N, ROM_WE_N} !== 3'b111) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=111",
                     {ROM_CE_N, ROM_OE_N, ROM_WE_N});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_k0;
        int n;
        logic [31:0] d;
        logic [12:0] a;
        int lat;
        lat = exp_lat(1, 0);
        do_req(1, 0, n, d, a);
        total++;
        if (n !== lat) begin
            bad++;
            $display("FAIL k0_latency got=%0d want=%0d", n, lat);
        end
        total++;
        if (d !== 32'h428a2f98) begin
            bad++;
            $display("FAIL k0_data got=%h want=428a2f98", d);
        end
        do_release(1, 0, 0);
    endtask

    task automatic test_h_words;
        int n;
        logic [31:0] d;
        logic [12:0] a;
        do_req(0, 0, n, d, a);
        total++;
        if (d !== 32'h6a09e667 || a !== 13'd0 || n !== FULL_LAT) begin
            bad++;
            $display("FAIL h0 got d=%h a=%0d n=%0d want 6a09e667/0/%0d",
                     d, a, n, FULL_LAT);
        end
        do_release(0, 0, 0);
        do_req(0, 7, n, d, a);
        total++;
        if (d !== 32'h5be0cd19 || a !== 13'd7 || n !== FULL_LAT) begin
            bad++;
            $display("FAIL h7 got d=%h a=%0d n=%0d want 5be0cd19/7/%0d",
                     d, a, n, FULL_LAT);
        end
        do_release(0, 7, 0);
    endtask

    task automatic test_simultaneous;
        int n;
        @(negedge CLK);
        H_IDX = 3'd7;
        K_IDX = 6'd5;
        H_REQ = 1'b1;
        K_REQ = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            #1;
            n++;
            if (K_ACK === 1'b1 || H_ACK === 1'b1)
                break;
        end
        total++;
        if ({K_ACK, H_ACK} !== 2'b10 || RDATA !== 32'h59f111f1) begin
            bad++;
            $display("FAIL sim_k_first got k=%b h=%b d=%h want 1/0/59f111f1",
                     K_ACK, H_ACK, RDATA);
        end
        do_release(1, 5, 1);
        n = 0;
        while (n < 40) begin
            @(posedge CLK);
            #1;
            n++;
            if (H_ACK === 1'b1)
                break;
        end
        total++;
        if (H_ACK !== 1'b1 || RDATA !== 32'h5be0cd19) begin
            bad++;
            $display("FAIL sim_h_second got h=%b d=%h want 1/5be0cd19",
                     H_ACK, RDATA);
        end
        do_release(0, 7, 0);
    endtask

    task automatic test_k63_hold;
        int n;
        int starts;
        logic [31:0] d;
        logic [12:0] a;
        do_req(1, 63, n, d, a);
        total++;
        if (d !== 32'hc67178f2 || a !== 13'd71) begin
            bad++;
            $display("FAIL k63 got d=%h a=%0d want c67178f2/71", d, a);
        end
        starts = ce_starts;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            total++;
            if ({K_ACK, ROM_CE_N, RDATA} !== {1'b1, 1'b1, 32'hc67178f2}) begin
                bad++;
                $display("FAIL k63_hold[%0d] got ack=%b ce_n=%b d=%h want 1/1/c67178f2",
                         i, K_ACK, ROM_CE_N, RDATA);
            end
        end
        total++;
        if (ce_starts !== starts) begin
            bad++;
            $display("FAIL k63_no_new_cycle got=%0d want=%0d", ce_starts, starts);
        end
        do_release(1, 63, 0);
    endtask

    task automatic test_reset_mid_fetch;
        int n;
        logic [31:0] d;
        logic [12:0] a;
        @(negedge CLK);
        K_IDX = 6'd10;
        K_REQ = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        total++;
        if ({ROM_CE_N, ROM_OE_N} !== 2'b00) begin
            bad++;
            $display("FAIL mid_access got ce_n/oe_n=%b want=00", {ROM_CE_N, ROM_OE_N});
        end
        RST_N = 1'b0;
        #1;
        total++;
        if ({K_ACK, H_ACK, BUSY, ROM_CE_N, ROM_OE_N, ROM_WE_N} !== 6'b000111 ||
            RDATA !== 32'hc67178f2 && RDATA !== 32'h0 || ROM_A !== 13'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got flags=%b a=%0d",
                     {K_ACK, H_ACK, BUSY, ROM_CE_N, ROM_OE_N, ROM_WE_N}, ROM_A);
        end
        total++;
        if (RDATA !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_rdata got=%h want=0", RDATA);
        end
        K_REQ = 1'b0;
        pf_valid = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        do_req(1, 10, n, d, a);
        total++;
        if (d !== 32'h243185be || n !== FULL_LAT) begin
            bad++;
            $display("FAIL rereq_k10 got d=%h n=%0d want 243185be/%0d", d, n, FULL_LAT);
        end
        do_release(1, 10, 0);
    endtask

    task automatic test_random;
        int n;
        int idx;
        int lat;
        int ea;
        bit is_k;
        logic [31:0] d;
        logic [12:0] a;
        for (int it = 0; it < 16; it++) begin
            is_k = bit'($urandom_range(0, 1));
            idx = is_k ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
`ifdef SHA_CONST_KPREFETCH_EN
            if (is_k && pf_valid && $urandom_range(0, 1) == 1)
                idx = pf_idx;
`endif
            lat = exp_lat(is_k, idx);
            ea = exp_addr(is_k, idx);
            do_req(is_k, idx, n, d, a);
            total++;
            if (d !== rom[ea] || n !== lat) begin
                bad++;
                $display("FAIL rand[%0d] k=%0d idx=%0d got d=%h n=%0d want %h/%0d",
                         it, is_k, idx, d, n, rom[ea], lat);
            end
            if (lat == FULL_LAT) begin
                total++;
                if (a !== 13'(ea)) begin
                    bad++;
                    $display("FAIL rand_addr[%0d] got=%0d want=%0d", it, a, ea);
                end
            end
            do_release(is_k, idx, 0);
        end
    endtask

`ifdef SHA_CONST_KPREFETCH_EN
    task automatic test_prefetch;
        int n;
        logic [31:0] d;
        logic [12:0] a;
        do_req(1, 3, n, d, a);
        total++;
        if (d !== 32'he9b5dba5 - 32'h0 && d !== 32'h0 || d !== rom[11]) begin
            bad++;
            $display("FAIL pf_k3 got=%h want=%h", d, rom[11]);
        end
        do_release(1, 3, 0);
        do_req(1, 4, n, d, a);
        total++;
        if (n !== 2 || d !== 32'h3956c25b) begin
            bad++;
            $display("FAIL pf_hit_k4 got n=%0d d=%h want 2/3956c25b", n, d);
        end
        do_release(1, 4, 0);
        do_req(1, 9, n, d, a);
        total++;
        if (n !== FULL_LAT || d !== 32'h12835b01) begin
            bad++;
            $display("FAIL pf_miss_k9 got n=%0d d=%h want %0d/12835b01", n, d, FULL_LAT);
        end
        do_release(1, 9, 0);
    endtask
`endif

    task automatic test_we_never_low;
        total++;
        if (we_low_seen !== 1'b0) begin
            bad++;
            $display("FAIL we_n_tied got low_seen=%0d want=0", we_low_seen);
        end
    endtask

    initial begin
        rom = '{
            32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
            32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
            32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
            32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
            32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
            32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
            32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
            32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
            32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        test_reset();
        test_k0();
        test_h_words();
        test_simultaneous();
        test_k63_hold();
        test_reset_mid_fetch();
`ifdef SHA_CONST_KPREFETCH_EN
        test_prefetch();
`endif
        test_random();
        test_we_never_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
